// File: rtl/cw305_reg_mailbox.sv
// cw305_reg_mailbox: per-channel word mailboxes between the CW305 byte-wide
// register bus (host side) and a word-wide valid/ready core interface.
// Each channel has an H2C FIFO (host push, core pop) and a C2H FIFO
// (core push, host pop), plus DATA / STATUS / CTRL registers. A shared
// IRQ_EN register follows the channel block.
module cw305_reg_mailbox #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pCHANNELS     = 2,
  parameter int pDATA_WIDTH   = 32,
  parameter int pDEPTH        = 8,
  parameter int pBASE_ADDR    = 'h40
) (
  input  logic                                   usb_clk,
  input  logic                                   reset_i,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
  input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
  input  logic                                   reg_addrvalid,
  input  logic                                   reg_read,
  input  logic                                   reg_write,
  input  logic [7:0]                             write_data,
  output logic [7:0]                             read_data,
  output logic [pCHANNELS*pDATA_WIDTH-1:0]       core_rx_data,
  output logic [pCHANNELS-1:0]                   core_rx_valid,
  input  logic [pCHANNELS-1:0]                   core_rx_ready,
  input  logic [pCHANNELS*pDATA_WIDTH-1:0]       core_tx_data,
  input  logic [pCHANNELS-1:0]                   core_tx_valid,
  output logic [pCHANNELS-1:0]                   core_tx_ready,
  output logic                                   irq
);

  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int BW = pBYTECNT_SIZE;
  localparam int NB = pDATA_WIDTH / 8;
  localparam int PW = $clog2(pDEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] IRQ_EN_ADDR = AW'(pBASE_ADDR + 3*pCHANNELS);
  localparam logic [CW-1:0] FULL_CNT    = CW'(pDEPTH);

  logic [pCHANNELS-1:0]      irq_en;
  logic [pCHANNELS-1:0]      c2h_empty_v;
  logic [pCHANNELS-1:0][7:0] ch_rd;
  logic [7:0]                rd_mux;
  logic                      sel_irq_en;

  assign sel_irq_en = reg_addrvalid && (reg_address == IRQ_EN_ADDR);

  for (genvar c = 0; c < pCHANNELS; c++) begin : g_ch
    localparam logic [AW-1:0] A_DATA = AW'(pBASE_ADDR + 3*c);
    localparam logic [AW-1:0] A_STAT = AW'(pBASE_ADDR + 3*c + 1);
    localparam logic [AW-1:0] A_CTRL = AW'(pBASE_ADDR + 3*c + 2);

    logic                   sel_data, sel_stat, sel_ctrl;
    logic                   data_wr, ctrl_wr;
    logic                   flush, host_pop_req, flag_clr;
    logic [NB-1:0][7:0]     stage;
    logic                   push_pend;
    logic [pDATA_WIDTH-1:0] h2c_mem [pDEPTH];
    logic [pDATA_WIDTH-1:0] c2h_mem [pDEPTH];
    logic [PW-1:0]          h2c_wp, h2c_rp, c2h_wp, c2h_rp;
    logic [CW-1:0]          h2c_cnt, c2h_cnt;
    logic                   h2c_empty, h2c_full, c2h_empty, c2h_full;
    logic                   h2c_push, h2c_pop, c2h_push, c2h_pop;
    logic                   ovf, udf, ovf_evt, udf_evt;
    logic [pDATA_WIDTH-1:0] c2h_head;
    logic [7:0]             rd_byte;

    assign sel_data = reg_addrvalid && (reg_address == A_DATA);
    assign sel_stat = reg_addrvalid && (reg_address == A_STAT);
    assign sel_ctrl = reg_addrvalid && (reg_address == A_CTRL);

    assign data_wr      = sel_data && reg_write && (reg_bytecnt < BW'(NB));
    assign ctrl_wr      = sel_ctrl && reg_write && (reg_bytecnt == '0);
    assign host_pop_req = ctrl_wr && write_data[0];
    assign flush        = ctrl_wr && write_data[1];
    assign flag_clr     = ctrl_wr && write_data[2];

    assign h2c_empty = (h2c_cnt == '0);
    assign h2c_full  = (h2c_cnt == FULL_CNT);
    assign c2h_empty = (c2h_cnt == '0);
    assign c2h_full  = (c2h_cnt == FULL_CNT);

    // A full H2C still accepts the staged word when the core drains one
    // in the same cycle; flush overrides every push and pop.
    assign h2c_pop  = !h2c_empty && core_rx_ready[c] && !flush;
    assign h2c_push = push_pend && !flush && (!h2c_full || h2c_pop);
    assign ovf_evt  = push_pend && !flush && h2c_full && !h2c_pop;
    assign c2h_push = core_tx_valid[c] && !c2h_full && !flush;
    assign c2h_pop  = host_pop_req && !c2h_empty && !flush;
    assign udf_evt  = host_pop_req && c2h_empty && !flush;

    assign core_rx_valid[c]                            = !h2c_empty;
    assign core_rx_data[c*pDATA_WIDTH +: pDATA_WIDTH]  = h2c_mem[h2c_rp];
    assign core_tx_ready[c]                            = !c2h_full;
    assign c2h_empty_v[c]                              = c2h_empty;
    assign c2h_head                                    = c2h_mem[c2h_rp];
    assign ch_rd[c]                                    = rd_byte;

    // Assemble the staging word byte by byte; the last byte schedules a push.
    always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
        stage     <= '0;
        push_pend <= 1'b0;
      end else begin
        push_pend <= data_wr && (reg_bytecnt == BW'(NB-1));
        for (int b = 0; b < NB; b++) begin
          if (data_wr && (reg_bytecnt == BW'(b))) stage[b] <= write_data;
        end
      end
    end

    // H2C pointers and occupancy.
    always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
        h2c_wp  <= '0;
        h2c_rp  <= '0;
        h2c_cnt <= '0;
      end else if (flush) begin
        h2c_wp  <= '0;
        h2c_rp  <= '0;
        h2c_cnt <= '0;
      end else begin
        if (h2c_push) h2c_wp <= h2c_wp + PW'(1);
        if (h2c_pop)  h2c_rp <= h2c_rp + PW'(1);
        case ({h2c_push, h2c_pop})
          2'b10:   h2c_cnt <= h2c_cnt + CW'(1);
          2'b01:   h2c_cnt <= h2c_cnt - CW'(1);
          default: h2c_cnt <= h2c_cnt;
        endcase
      end
    end

    // C2H pointers and occupancy.
    always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
        c2h_wp  <= '0;
        c2h_rp  <= '0;
        c2h_cnt <= '0;
      end else if (flush) begin
        c2h_wp  <= '0;
        c2h_rp  <= '0;
        c2h_cnt <= '0;
      end else begin
        if (c2h_push) c2h_wp <= c2h_wp + PW'(1);
        if (c2h_pop)  c2h_rp <= c2h_rp + PW'(1);
        case ({c2h_push, c2h_pop})
          2'b10:   c2h_cnt <= c2h_cnt + CW'(1);
          2'b01:   c2h_cnt <= c2h_cnt - CW'(1);
          default: c2h_cnt <= c2h_cnt;
        endcase
      end
    end

    // FIFO storage is not reset; pointers alone define what is valid.
    always_ff @(posedge usb_clk) begin
      if (h2c_push) h2c_mem[h2c_wp] <= stage;
      if (c2h_push) c2h_mem[c2h_wp] <= core_tx_data[c*pDATA_WIDTH +: pDATA_WIDTH];
    end

    // Sticky error flags; a new event in the clearing cycle keeps its flag set.
    always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (flag_clr) begin
          ovf <= 1'b0;
          udf <= 1'b0;
        end
        if (ovf_evt) ovf <= 1'b1;
        if (udf_evt) udf <= 1'b1;
      end
    end

    // Per-channel read byte for DATA and STATUS; CTRL always reads 0.
    always_comb begin
      rd_byte = 8'h00;
      if (sel_data && !c2h_empty) begin
        for (int b = 0; b < NB; b++) begin
          if (reg_bytecnt == BW'(b)) rd_byte = c2h_head[8*b +: 8];
        end
      end else if (sel_stat) begin
        if (reg_bytecnt == '0)
          rd_byte = {2'b00, udf, ovf, c2h_full, c2h_empty, h2c_full, h2c_empty};
        else if (reg_bytecnt == BW'(1))
          rd_byte = 8'(h2c_cnt);
        else if (reg_bytecnt == BW'(2))
          rd_byte = 8'(c2h_cnt);
      end
    end
  end

  // Merge channel read bytes with the IRQ_EN readback.
  always_comb begin
    rd_mux = 8'h00;
    for (int c = 0; c < pCHANNELS; c++) rd_mux = rd_mux | ch_rd[c];
    if (sel_irq_en && (reg_bytecnt == '0)) rd_mux = rd_mux | 8'(irq_en);
  end

  // Registered read data, zero whenever no read is in progress.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) read_data <= 8'h00;
    else         read_data <= reg_read ? rd_mux : 8'h00;
  end

  // Interrupt enable register.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i)
      irq_en <= '0;
    else if (sel_irq_en && reg_write && (reg_bytecnt == '0))
      irq_en <= write_data[pCHANNELS-1:0];
  end

  // Interrupt whenever an enabled channel has a word waiting for the host.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) irq <= 1'b0;
    else         irq <= |(irq_en & ~c2h_empty_v);
  end

endmodule

// File: tb/tb_cw305_reg_mailbox.sv
// Bench for cw305_reg_mailbox with default parameters: a register table,
// hand-written multi-cycle sequences, and a randomized run against a
// queue-based model of the mailbox.
module tb_cw305_reg_mailbox;
  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam int OP_WR = 0, OP_RD = 1, OP_IDLE = 2;

  logic                usb_clk = 1'b0;
  logic                reset_i;
  logic [AW-1:0]       reg_address;
  logic [6:0]          reg_bytecnt;
  logic                reg_addrvalid, reg_read, reg_write;
  logic [7:0]          write_data;
  logic [7:0]          read_data;
  logic [NCH*DW-1:0]   core_rx_data;
  logic [NCH-1:0]      core_rx_valid;
  logic [NCH-1:0]      core_rx_ready;
  logic [NCH*DW-1:0]   core_tx_data;
  logic [NCH-1:0]      core_tx_valid;
  logic [NCH-1:0]      core_tx_ready;
  logic                irq;

  always #5 usb_clk = ~usb_clk;

  cw305_reg_mailbox dut (
    .usb_clk       (usb_clk),
    .reset_i       (reset_i),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .reg_addrvalid (reg_addrvalid),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .write_data    (write_data),
    .read_data     (read_data),
    .core_rx_data  (core_rx_data),
    .core_rx_valid (core_rx_valid),
    .core_rx_ready (core_rx_ready),
    .core_tx_data  (core_tx_data),
    .core_tx_valid (core_tx_valid),
    .core_tx_ready (core_tx_ready),
    .irq           (irq)
  );

  typedef struct {
    int op;
    int addr;
    int bc;
    int wd;
    int exp;
  } vec_t;

  vec_t tbl[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model
  logic [31:0] h2c_q [NCH][$];
  logic [31:0] c2h_q [NCH][$];
  bit          m_ovf [NCH];
  bit          m_udf [NCH];
  logic [1:0]  m_irq_en;

  function automatic int a_data(int c); return 'h40 + 3*c; endfunction
  function automatic int a_stat(int c); return 'h41 + 3*c; endfunction
  function automatic int a_ctrl(int c); return 'h42 + 3*c; endfunction
  localparam int A_IRQ_EN = 'h46;

  function automatic void add(int op, int a, int b, int wd, int ex);
    vec_t v;
    v.op = op; v.addr = a; v.bc = b; v.wd = wd; v.exp = ex;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input int a, input int b, input int d);
    reg_address   = AW'(a);
    reg_bytecnt   = 7'(b);
    write_data    = 8'(d);
    reg_addrvalid = 1'b1;
    reg_write     = 1'b1;
    @(negedge usb_clk);
    reg_addrvalid = 1'b0;
    reg_write     = 1'b0;
  endtask

  task automatic bus_read(input int a, input int b, output logic [7:0] d);
    reg_address   = AW'(a);
    reg_bytecnt   = 7'(b);
    reg_addrvalid = 1'b1;
    reg_read      = 1'b1;
    @(negedge usb_clk);
    d             = read_data;
    reg_addrvalid = 1'b0;
    reg_read      = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int a, input int b, input int exp);
    logic [7:0] d;
    bus_read(a, b, d);
    chk(nm, d, 64'(exp));
  endtask

  task automatic write_word(input int c, input logic [31:0] w);
    for (int b = 0; b < 4; b++) bus_write(a_data(c), b, int'(w[8*b +: 8]));
    @(negedge usb_clk);
  endtask

  task automatic core_push(input int c, input logic [31:0] w);
    core_tx_data[c*DW +: DW] = w;
    core_tx_valid[c] = 1'b1;
    @(negedge usb_clk);
    core_tx_valid[c] = 1'b0;
  endtask

  task automatic core_pop(input int c);
    core_rx_ready[c] = 1'b1;
    @(negedge usb_clk);
    core_rx_ready[c] = 1'b0;
  endtask

  function automatic logic [7:0] exp_reg(int c, int kind, int bc);
    logic [7:0]  s;
    logic [31:0] w;
    s = 8'h00;
    case (kind)
      0: if (bc < 4 && c2h_q[c].size() > 0) begin
           w = c2h_q[c][0];
           s = w[8*bc +: 8];
         end
      1: begin
           if (bc == 0) begin
             s[0] = (h2c_q[c].size() == 0);
             s[1] = (h2c_q[c].size() == DEPTH);
             s[2] = (c2h_q[c].size() == 0);
             s[3] = (c2h_q[c].size() == DEPTH);
             s[4] = m_ovf[c];
             s[5] = m_udf[c];
           end else if (bc == 1) s = 8'(h2c_q[c].size());
           else if (bc == 2) s = 8'(c2h_q[c].size());
         end
      3: if (bc == 0) s = {6'b0, m_irq_en};
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic bit exp_irq();
    bit e = 1'b0;
    for (int c = 0; c < NCH; c++) if (m_irq_en[c] && c2h_q[c].size() > 0) e = 1'b1;
    return e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] exp_seq [8];
    logic [7:0]  d;
    logic [7:0]  v;
    int          c, r, kind, bc;

    reset_i = 1'b1;
    reg_address = '0; reg_bytecnt = '0; write_data = '0;
    reg_addrvalid = 1'b0; reg_read = 1'b0; reg_write = 1'b0;
    core_rx_ready = '0; core_tx_valid = '0; core_tx_data = '0;
    repeat (3) @(negedge usb_clk);
    chk("rst_tx_ready", core_tx_ready, 2'b11);
    chk("rst_rx_valid", core_rx_valid, 2'b00);
    chk("rst_irq", irq, 0);
    chk("rst_read_data", read_data, 0);
    reset_i = 1'b0;

    // first host word assembles little-endian and reaches the core
    bus_write(a_data(0), 0, 'h11);
    bus_write(a_data(0), 1, 'h22);
    bus_write(a_data(0), 2, 'h33);
    chk("partial_no_valid", core_rx_valid[0], 0);
    bus_write(a_data(0), 3, 'h44);
    @(negedge usb_clk);
    chk("word_rx_valid", core_rx_valid[0], 1);
    chk("word_rx_data", core_rx_data[31:0], 32'h44332211);

    // register table; H2C(0) holds one word at entry
    add(OP_RD,   A_IRQ_EN,  0, 0,    'h00);
    add(OP_RD,   a_stat(0), 0, 0,    'h04);
    add(OP_RD,   a_stat(0), 1, 0,    'h01);
    add(OP_RD,   a_stat(0), 2, 0,    'h00);
    add(OP_RD,   a_stat(0), 3, 0,    'h00);
    add(OP_RD,   a_stat(1), 0, 0,    'h05);
    add(OP_RD,   a_ctrl(0), 0, 0,    'h00);
    add(OP_RD,   'h3F,      0, 0,    'h00);
    add(OP_RD,   'h47,      0, 0,    'h00);
    add(OP_WR,   A_IRQ_EN,  0, 'hFF, 0);
    add(OP_RD,   A_IRQ_EN,  0, 0,    'h03);
    add(OP_WR,   A_IRQ_EN,  0, 'h00, 0);
    add(OP_RD,   A_IRQ_EN,  0, 0,    'h00);
    add(OP_WR,   a_data(0), 4, 'h99, 0);
    add(OP_IDLE, 0,         0, 0,    0);
    add(OP_RD,   a_stat(0), 1, 0,    'h01);
    add(OP_WR,   a_ctrl(0), 0, 'h01, 0);
    add(OP_RD,   a_stat(0), 0, 0,    'h24);
    add(OP_WR,   a_ctrl(0), 0, 'h04, 0);
    add(OP_RD,   a_stat(0), 0, 0,    'h04);
    add(OP_RD,   a_data(0), 0, 0,    'h00);
    add(OP_WR,   a_ctrl(0), 0, 'h02, 0);
    add(OP_RD,   a_stat(0), 0, 0,    'h05);
    add(OP_RD,   a_stat(0), 1, 0,    'h00);
    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_WR:   bus_write(tbl[i].addr, tbl[i].bc, tbl[i].wd);
        OP_RD:   rd_chk($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].bc, tbl[i].exp);
        default: @(negedge usb_clk);
      endcase
    end
    chk("rd_idle_zero", read_data, 0);

    // core fills C2H(1), host pops one
    for (int i = 0; i < 8; i++) core_push(1, {8'(8'hA0 + i), 8'h5A, 8'hC3, 8'(8'h10 + i)});
    chk("c2h_full_ready", core_tx_ready[1], 0);
    rd_chk("c2h_full_stat0", a_stat(1), 0, 'h09);
    rd_chk("c2h_full_cnt", a_stat(1), 2, 8);
    rd_chk("c2h_head_b0", a_data(1), 0, 'h10);
    rd_chk("c2h_head_b3", a_data(1), 3, 'hA0);
    bus_write(a_ctrl(1), 0, 'h01);
    chk("c2h_pop_ready", core_tx_ready[1], 1);
    rd_chk("c2h_pop_cnt", a_stat(1), 2, 7);
    rd_chk("c2h_pop_head", a_data(1), 0, 'h11);

    // interrupt follows enabled C2H occupancy one cycle late
    bus_write(a_ctrl(1), 0, 'h02);
    bus_write(A_IRQ_EN, 0, 'h02);
    core_push(1, 32'h1234_5678);
    chk("irq_latency", irq, 0);
    @(negedge usb_clk);
    chk("irq_set", irq, 1);
    bus_write(a_ctrl(1), 0, 'h01);
    @(negedge usb_clk);
    chk("irq_clear", irq, 0);
    core_push(0, 32'h0BAD_F00D);
    @(negedge usb_clk);
    @(negedge usb_clk);
    chk("irq_masked", irq, 0);
    bus_write(a_ctrl(0), 0, 'h02);
    bus_write(A_IRQ_EN, 0, 'h00);

    // H2C(0) overflow
    for (int i = 0; i < 9; i++) write_word(0, 32'hC0DE_0000 + 32'(i));
    rd_chk("ovf_cnt", a_stat(0), 1, 8);
    rd_chk("ovf_stat0", a_stat(0), 0, 'h16);
    chk("ovf_head", core_rx_data[31:0], 32'hC0DE_0000);
    bus_write(a_ctrl(0), 0, 'h04);
    rd_chk("ovf_cleared", a_stat(0), 0, 'h06);

    // full H2C: host push and core pop in the same cycle
    w = 32'hFACE_0001;
    for (int b = 0; b < 4; b++) bus_write(a_data(0), b, int'(w[8*b +: 8]));
    core_rx_ready[0] = 1'b1;
    @(negedge usb_clk);
    core_rx_ready[0] = 1'b0;
    rd_chk("pushpop_cnt", a_stat(0), 1, 8);
    rd_chk("pushpop_stat0", a_stat(0), 0, 'h06);
    for (int i = 0; i < 7; i++) exp_seq[i] = 32'hC0DE_0001 + 32'(i);
    exp_seq[7] = 32'hFACE_0001;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain[%0d]", i), core_rx_data[31:0], exp_seq[i]);
      core_pop(0);
    end
    chk("drain_empty", core_rx_valid[0], 0);

    // reset with traffic queued and a half-written staging word
    for (int i = 0; i < 3; i++) write_word(0, 32'h7700_0000 + 32'(i));
    core_push(1, 32'h0101_0101);
    core_push(1, 32'h0202_0202);
    bus_write(A_IRQ_EN, 0, 'h02);
    bus_write(a_data(0), 0, 'hEE);
    bus_write(a_data(0), 1, 'hDD);
    @(negedge usb_clk);
    chk("pre_rst_irq", irq, 1);
    #2 reset_i = 1'b1;
    #1;
    chk("arst_rx_valid", core_rx_valid, 2'b00);
    chk("arst_tx_ready", core_tx_ready, 2'b11);
    chk("arst_irq", irq, 0);
    @(negedge usb_clk);
    reset_i = 1'b0;
    write_word(0, 32'h5566_7788);
    chk("post_rst_valid", core_rx_valid[0], 1);
    chk("post_rst_word", core_rx_data[31:0], 32'h5566_7788);
    rd_chk("post_rst_h2c_cnt", a_stat(0), 1, 1);
    rd_chk("post_rst_c2h1_cnt", a_stat(1), 2, 0);
    rd_chk("post_rst_data0", a_data(0), 0, 0);
    rd_chk("post_rst_irq_en", A_IRQ_EN, 0, 0);
    chk("post_rst_irq", irq, 0);
    bus_write(a_ctrl(0), 0, 'h06);
    bus_write(a_ctrl(1), 0, 'h06);

    // randomized traffic against the queue model
    for (int k = 0; k < NCH; k++) begin
      h2c_q[k].delete(); c2h_q[k].delete();
      m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
    end
    m_irq_en = 2'b00;
    for (int it = 0; it < 400; it++) begin
      c = $urandom_range(0, NCH-1);
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        w = $urandom;
        write_word(c, w);
        if (h2c_q[c].size() == DEPTH) m_ovf[c] = 1'b1;
        else h2c_q[c].push_back(w);
      end else if (r == 3) begin
        if (h2c_q[c].size() > 0) begin
          chk($sformatf("rnd_rx_valid[%0d]", it), core_rx_valid[c], 1);
          chk($sformatf("rnd_rx_data[%0d]", it), core_rx_data[c*DW +: DW], h2c_q[c][0]);
          core_pop(c);
          void'(h2c_q[c].pop_front());
        end else begin
          chk($sformatf("rnd_rx_empty[%0d]", it), core_rx_valid[c], 0);
        end
      end else if (r <= 5) begin
        w = $urandom;
        chk($sformatf("rnd_tx_ready[%0d]", it), core_tx_ready[c], (c2h_q[c].size() < DEPTH) ? 1 : 0);
        core_push(c, w);
        if (c2h_q[c].size() < DEPTH) c2h_q[c].push_back(w);
      end else if (r == 6) begin
        case ($urandom_range(0, 3))
          0:       v = 8'h01;
          1:       v = 8'h02;
          2:       v = 8'h04;
          default: v = 8'h03;
        endcase
        bus_write(a_ctrl(c), 0, int'(v));
        if (v[1]) begin
          h2c_q[c].delete();
          c2h_q[c].delete();
        end else if (v[0]) begin
          if (c2h_q[c].size() == 0) m_udf[c] = 1'b1;
          else void'(c2h_q[c].pop_front());
        end
        if (v[2]) begin
          m_ovf[c] = 1'b0;
          m_udf[c] = 1'b0;
        end
      end else if (r <= 8) begin
        kind = $urandom_range(0, 3);
        bc   = $urandom_range(0, 4);
        case (kind)
          0:       bus_read(a_data(c), bc, d);
          1:       bus_read(a_stat(c), bc, d);
          2:       bus_read(a_ctrl(c), bc, d);
          default: bus_read(A_IRQ_EN, bc, d);
        endcase
        chk($sformatf("rnd_read[%0d] k%0d c%0d b%0d", it, kind, c, bc), d, exp_reg(c, kind, bc));
      end else begin
        v = 8'($urandom);
        bus_write(A_IRQ_EN, 0, int'(v));
        m_irq_en = v[1:0];
      end
      @(negedge usb_clk);
      chk($sformatf("rnd_irq[%0d]", it), irq, exp_irq());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
